prim_assembler: RTL and testbench

Primitive assembly controller between instruction decode and the rasterizer. Consumes the decode stream (StartPrimitive, Vertex/Draw, EndPrimitive, PrimitiveType), groups vertices into points, lines or triangles per topology, and hands each to the rasterizer over a valid/ready handshake. While its output register is occupied, it back-pressures fetch/decode with Stall.

---
 rtl/gpu_prim_pkg.sv | 47 ++++
 rtl/prim_emit_logic.sv | 110 +++++++++++
 rtl/prim_assembler.sv | 161 ++++++++++++++++
 tb/tb_prim_assembler.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/gpu_prim_pkg.sv
// Shared definitions for the primitive assembler.
// Holds topology and primitive-kind codes, the controller state enum and the
// vertex-history record carried between accepted Draw cycles.
// No ports (package).
package gpu_prim_pkg;

    // Vertex word width used by the history record; the top-level VERTEX_W
    // parameter must be left at this value.
    localparam int VTX_W = 32;

    localparam logic [3:0] TOPO_POINTS     = 4'd0;
    localparam logic [3:0] TOPO_LINES      = 4'd1;
    localparam logic [3:0] TOPO_LINE_STRIP = 4'd2;
    localparam logic [3:0] TOPO_TRIANGLES  = 4'd3;
    localparam logic [3:0] TOPO_TRI_STRIP  = 4'd4;
    localparam logic [3:0] TOPO_TRI_FAN    = 4'd5;

    localparam logic [1:0] KIND_POINT = 2'd0;
    localparam logic [1:0] KIND_LINE  = 2'd1;
    localparam logic [1:0] KIND_TRI   = 2'd2;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    // a = older, b = most recent vertex, pivot = first vertex of a fan.
    // vcnt counts held vertices; 3 marks a sliding strip/fan history whose
    // vertices already belong to an emitted primitive.
    typedef struct packed {
        logic [VTX_W-1:0] a;
        logic [VTX_W-1:0] b;
        logic [VTX_W-1:0] pivot;
        logic [1:0]       vcnt;
        logic             parity;
    } hist_t;

    function automatic logic topo_legal(input logic [3:0] t);
        return (t <= TOPO_TRI_FAN);
    endfunction

    // Vertices that would be thrown away if the group closed now.
    function automatic logic [1:0] partial_cnt(input hist_t h);
        return (h.vcnt == 2'd3) ? 2'd0 : h.vcnt;
    endfunction

endpackage

// File: rtl/prim_emit_logic.sv
// Combinational topology decision for one incoming vertex.
// Ports:
//   hist     in   vertex history before this vertex
//   topo     in   active topology code (must be legal)
//   vtx      in   incoming vertex
//   emit     out  a primitive completes with this vertex
//   kind     out  primitive kind (point/line/triangle)
//   v0,v1,v2 out  ordered primitive vertices, unused slots 0
//   hist_nxt out  history after absorbing this vertex
module prim_emit_logic
    import gpu_prim_pkg::*;
(
    input  hist_t             hist,
    input  logic [3:0]        topo,
    input  logic [VTX_W-1:0]  vtx,
    output logic              emit,
    output logic [1:0]        kind,
    output logic [VTX_W-1:0]  v0,
    output logic [VTX_W-1:0]  v1,
    output logic [VTX_W-1:0]  v2,
    output hist_t             hist_nxt
);

    always_comb begin
        emit     = 1'b0;
        kind     = KIND_POINT;
        v0       = '0;
        v1       = '0;
        v2       = '0;
        hist_nxt = hist;
        case (topo)
            TOPO_POINTS: begin
                emit = 1'b1;
                v0   = vtx;
            end
            TOPO_LINES: begin
                if (hist.vcnt == 2'd1) begin
                    emit          = 1'b1;
                    kind          = KIND_LINE;
                    v0            = hist.b;
                    v1            = vtx;
                    hist_nxt.vcnt = 2'd0;
                end else begin
                    hist_nxt.b    = vtx;
                    hist_nxt.vcnt = 2'd1;
                end
            end
            TOPO_LINE_STRIP: begin
                hist_nxt.b = vtx;
                if (hist.vcnt != 2'd0) begin
                    emit          = 1'b1;
                    kind          = KIND_LINE;
                    v0            = hist.b;
                    v1            = vtx;
                    hist_nxt.vcnt = 2'd3;
                end else begin
                    hist_nxt.vcnt = 2'd1;
                end
            end
            TOPO_TRIANGLES: begin
                if (hist.vcnt == 2'd2) begin
                    emit          = 1'b1;
                    kind          = KIND_TRI;
                    v0            = hist.a;
                    v1            = hist.b;
                    v2            = vtx;
                    hist_nxt.vcnt = 2'd0;
                end else begin
                    hist_nxt.a    = hist.b;
                    hist_nxt.b    = vtx;
                    hist_nxt.vcnt = hist.vcnt + 2'd1;
                end
            end
            TOPO_TRI_STRIP: begin
                hist_nxt.a = hist.b;
                hist_nxt.b = vtx;
                if (hist.vcnt >= 2'd2) begin
                    emit = 1'b1;
                    kind = KIND_TRI;
                    // Odd triangles swap the first two vertices to keep winding.
                    v0   = hist.parity ? hist.b : hist.a;
                    v1   = hist.parity ? hist.a : hist.b;
                    v2   = vtx;
                    hist_nxt.parity = ~hist.parity;
                    hist_nxt.vcnt   = 2'd3;
                end else begin
                    hist_nxt.vcnt = hist.vcnt + 2'd1;
                end
            end
            TOPO_TRI_FAN: begin
                hist_nxt.b = vtx;
                if (hist.vcnt == 2'd0) begin
                    hist_nxt.pivot = vtx;
                end
                if (hist.vcnt >= 2'd2) begin
                    emit          = 1'b1;
                    kind          = KIND_TRI;
                    v0            = hist.pivot;
                    v1            = hist.b;
                    v2            = vtx;
                    hist_nxt.vcnt = 2'd3;
                end else begin
                    hist_nxt.vcnt = hist.vcnt + 2'd1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/prim_assembler.sv
// Primitive assembly controller: groups decoded vertices into points, lines
// and triangles and hands them to the rasterizer over valid/ready.
// Optional feature macro: PRIM_STATS_EN adds PrimCount / DropCount.
// Ports:
//   CLOCK_50, Reset (async, active-low)
//   StartPrimitive, EndPrimitive, Draw, PrimitiveType, Vertex  decode stream
//   Stall         upstream hold (PrimValid & ~PrimReady)
//   PrimValid/PrimReady, PrimKind, PrimV0..2                  rasterizer side
//   GroupDone, Error                                          one-cycle pulses
//   PrimCount, DropCount                                      saturating stats
//
// state   | meaning
// IDLE    | no open group; Draw is an error
// COLLECT | group open, vertices accumulate in history
module prim_assembler
    import gpu_prim_pkg::*;
#(
    parameter int VERTEX_W = 32,
    parameter int CNT_W    = 16
) (
    input  logic                CLOCK_50,
    input  logic                Reset,
    input  logic                StartPrimitive,
    input  logic                EndPrimitive,
    input  logic                Draw,
    input  logic [3:0]          PrimitiveType,
    input  logic [VERTEX_W-1:0] Vertex,
    output logic                Stall,
    output logic                PrimValid,
    input  logic                PrimReady,
    output logic [1:0]          PrimKind,
    output logic [VERTEX_W-1:0] PrimV0,
    output logic [VERTEX_W-1:0] PrimV1,
    output logic [VERTEX_W-1:0] PrimV2,
    output logic                GroupDone,
    output logic                Error
`ifdef PRIM_STATS_EN
    ,
    output logic [CNT_W-1:0]    PrimCount,
    output logic [CNT_W-1:0]    DropCount
`endif
);

    state_t             state_q, state_nxt;
    logic [3:0]         topo_q;
    hist_t              hist_q, hist_eff, hist_new, hist_after;
    logic               accept, start_ok, in_grp;
    logic [3:0]         topo_eff;
    logic               emit, do_emit, done_nxt, err_nxt;
    logic [1:0]         e_kind;
    logic [VERTEX_W-1:0] e_v0, e_v1, e_v2;

    assign Stall    = PrimValid & ~PrimReady;
    assign accept   = ~Stall;
    assign start_ok = StartPrimitive & topo_legal(PrimitiveType);

    prim_emit_logic u_emit (
        .hist     (hist_eff),
        .topo     (topo_eff),
        .vtx      (Vertex),
        .emit     (emit),
        .kind     (e_kind),
        .v0       (e_v0),
        .v1       (e_v1),
        .v2       (e_v2),
        .hist_nxt (hist_new)
    );

    always_ff @(posedge CLOCK_50 or negedge Reset) begin
        if (!Reset) state_q <= IDLE;
        else        state_q <= state_nxt;
    end

    // Order within a cycle: Start, then Draw, then End.
    always_comb begin
        state_nxt = state_q;
        if (accept) begin
            if (StartPrimitive) state_nxt = start_ok ? COLLECT : IDLE;
            if (EndPrimitive)   state_nxt = IDLE;
        end
    end

    always_comb begin
        in_grp     = StartPrimitive ? start_ok : (state_q == COLLECT);
        topo_eff   = StartPrimitive ? PrimitiveType : topo_q;
        hist_eff   = StartPrimitive ? '0 : hist_q;
        hist_after = (Draw && in_grp) ? hist_new : hist_eff;
        do_emit    = accept & Draw & in_grp & emit;
        done_nxt   = accept & EndPrimitive & in_grp;
        err_nxt    = accept & ((StartPrimitive & ~start_ok) | (Draw & ~in_grp));
    end

    always_ff @(posedge CLOCK_50 or negedge Reset) begin
        if (!Reset) begin
            topo_q <= TOPO_POINTS;
            hist_q <= '0;
        end else if (accept) begin
            if (start_ok) topo_q <= PrimitiveType;
            hist_q <= hist_after;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge Reset) begin
        if (!Reset) begin
            PrimValid <= 1'b0;
            PrimKind  <= KIND_POINT;
            PrimV0    <= '0;
            PrimV1    <= '0;
            PrimV2    <= '0;
            GroupDone <= 1'b0;
            Error     <= 1'b0;
        end else begin
            if (do_emit) begin
                PrimValid <= 1'b1;
                PrimKind  <= e_kind;
                PrimV0    <= e_v0;
                PrimV1    <= e_v1;
                PrimV2    <= e_v2;
            end else if (PrimReady) begin
                PrimValid <= 1'b0;
            end
            GroupDone <= done_nxt;
            Error     <= err_nxt;
        end
    end

`ifdef PRIM_STATS_EN
    logic [2:0]     drop_inc;
    logic [CNT_W:0] drop_sum;

    // Partials lost to an implicit end, a Draw with no group, or an End.
    always_comb begin
        drop_inc = 3'd0;
        if (accept) begin
            if (StartPrimitive && state_q == COLLECT)
                drop_inc = drop_inc + {1'b0, partial_cnt(hist_q)};
            if (Draw && !in_grp)
                drop_inc = drop_inc + 3'd1;
            if (EndPrimitive && in_grp)
                drop_inc = drop_inc + {1'b0, partial_cnt(hist_after)};
        end
        drop_sum = {1'b0, DropCount} + (CNT_W+1)'(drop_inc);
    end

    always_ff @(posedge CLOCK_50 or negedge Reset) begin
        if (!Reset) begin
            PrimCount <= '0;
            DropCount <= '0;
        end else begin
            if (PrimValid && PrimReady && !(&PrimCount))
                PrimCount <= PrimCount + 1'b1;
            DropCount <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        end
    end
`else
    // Counter width only matters when statistics are built in.
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

endmodule

// File: tb/tb_prim_assembler.sv
module tb_prim_assembler;

    logic        CLOCK_50 = 1'b0;
    logic        Reset;
    logic        StartPrimitive, EndPrimitive, Draw, PrimReady;
    logic [3:0]  PrimitiveType;
    logic [31:0] Vertex;
    logic        Stall, PrimValid, GroupDone, Error;
    logic [1:0]  PrimKind;
    logic [31:0] PrimV0, PrimV1, PrimV2;
`ifdef PRIM_STATS_EN
    logic [15:0] PrimCount, DropCount;
`endif

    int total = 0;
    int bad   = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    prim_assembler dut (
        .CLOCK_50       (CLOCK_50),
        .Reset          (Reset),
        .StartPrimitive (StartPrimitive),
        .EndPrimitive   (EndPrimitive),
        .Draw           (Draw),
        .PrimitiveType  (PrimitiveType),
        .Vertex         (Vertex),
        .Stall          (Stall),
        .PrimValid      (PrimValid),
        .PrimReady      (PrimReady),
        .PrimKind       (PrimKind),
        .PrimV0         (PrimV0),
        .PrimV1         (PrimV1),
        .PrimV2         (PrimV2),
        .GroupDone      (GroupDone),
        .Error          (Error)
`ifdef PRIM_STATS_EN
        ,
        .PrimCount      (PrimCount),
        .DropCount      (DropCount)
`endif
    );

    typedef struct {
        logic        s, e, d;
        logic [3:0]  t;
        logic [31:0] v;
        logic        rdy;
        logic        x_valid;
        logic [1:0]  x_kind;
        logic [31:0] x0, x1, x2;
        logic        x_done, x_err;
    } vec_t;

    function automatic vec_t mk(input logic s, e, d, input logic [3:0] t,
                                input logic [31:0] v, input logic rdy,
                                input logic xv, input logic [1:0] xk,
                                input logic [31:0] x0, x1, x2,
                                input logic xd, xe);
        vec_t r;
        r.s = s; r.e = e; r.d = d; r.t = t; r.v = v; r.rdy = rdy;
        r.x_valid = xv; r.x_kind = xk; r.x0 = x0; r.x1 = x1; r.x2 = x2;
        r.x_done = xd; r.x_err = xe;
        return r;
    endfunction

    task automatic check(input string name, input vec_t x, input logic x_stall);
        total++;
        if (PrimValid !== x.x_valid || PrimKind !== x.x_kind || PrimV0 !== x.x0 ||
            PrimV1 !== x.x1 || PrimV2 !== x.x2 || GroupDone !== x.x_done ||
            Error !== x.x_err || Stall !== x_stall) begin
            bad++;
            $display("FAIL %s: got valid=%0d kind=%0d v=%h/%h/%h done=%0d err=%0d stall=%0d want valid=%0d kind=%0d v=%h/%h/%h done=%0d err=%0d stall=%0d",
                     name, PrimValid, PrimKind, PrimV0, PrimV1, PrimV2, GroupDone, Error, Stall,
                     x.x_valid, x.x_kind, x.x0, x.x1, x.x2, x.x_done, x.x_err, x_stall);
        end
    endtask

    // Drive one cycle of inputs, let one edge pass, check on the falling edge.
    task automatic step(input string name, input vec_t x);
        StartPrimitive = x.s; EndPrimitive = x.e; Draw = x.d;
        PrimitiveType = x.t; Vertex = x.v; PrimReady = x.rdy;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check(name, x, x.x_valid & ~x.rdy);
    endtask

    vec_t tbl[$];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        Reset = 1'b0; StartPrimitive = 0; EndPrimitive = 0; Draw = 0;
        PrimitiveType = 0; Vertex = 0; PrimReady = 1;
        repeat (2) @(negedge CLOCK_50);
        check("reset", mk(0,0,0,0,0,1, 0,0,0,0,0, 0,0), 1'b0);
        Reset = 1'b1;

        // TRIANGLES closed after two vertices: nothing emitted.
        step("tri_drop_a", mk(1,0,1,3,32'h1,1, 0,0,0,0,0, 0,0));
        step("tri_drop_b", mk(0,0,1,0,32'h2,1, 0,0,0,0,0, 0,0));
        step("tri_drop_end", mk(0,1,0,0,0,1, 0,0,0,0,0, 1,0));
`ifdef PRIM_STATS_EN
        total++;
        if (DropCount !== 16'd2) begin
            bad++;
            $display("FAIL drop_tri: got %0d want 2", DropCount);
        end
`endif

        // POINTS, TRI_STRIP, illegal topology, empty group, LINES.
        tbl.push_back(mk(1,0,0,0,0,1,     0,0,0,0,0, 0,0));
        tbl.push_back(mk(0,0,1,0,'h11,1,  1,0,'h11,0,0, 0,0));
        tbl.push_back(mk(0,0,1,0,'h22,1,  1,0,'h22,0,0, 0,0));
        tbl.push_back(mk(0,0,1,0,'h33,1,  1,0,'h33,0,0, 0,0));
        tbl.push_back(mk(0,1,0,0,0,1,     0,0,'h33,0,0, 1,0));
        tbl.push_back(mk(0,0,0,0,0,1,     0,0,'h33,0,0, 0,0));
        tbl.push_back(mk(1,0,1,4,'hA,1,   0,0,'h33,0,0, 0,0));
        tbl.push_back(mk(0,0,1,0,'hB,1,   0,0,'h33,0,0, 0,0));
        tbl.push_back(mk(0,0,1,0,'hC,1,   1,2,'hA,'hB,'hC, 0,0));
        tbl.push_back(mk(0,0,1,0,'hD,1,   1,2,'hC,'hB,'hD, 0,0));
        tbl.push_back(mk(0,1,1,0,'hE,1,   1,2,'hC,'hD,'hE, 1,0));
        tbl.push_back(mk(0,0,0,0,0,1,     0,2,'hC,'hD,'hE, 0,0));
        tbl.push_back(mk(1,0,0,7,0,1,     0,2,'hC,'hD,'hE, 0,1));
        tbl.push_back(mk(0,0,1,0,'h55,1,  0,2,'hC,'hD,'hE, 0,1));
        tbl.push_back(mk(0,0,0,0,0,1,     0,2,'hC,'hD,'hE, 0,0));
        tbl.push_back(mk(1,1,0,1,0,1,     0,2,'hC,'hD,'hE, 1,0));
        tbl.push_back(mk(0,0,1,0,'h66,1,  0,2,'hC,'hD,'hE, 0,1));
        tbl.push_back(mk(1,0,0,1,0,1,     0,2,'hC,'hD,'hE, 0,0));
        tbl.push_back(mk(0,0,1,0,'h1,1,   0,2,'hC,'hD,'hE, 0,0));
        tbl.push_back(mk(0,0,1,0,'h2,1,   1,1,'h1,'h2,0, 0,0));
        tbl.push_back(mk(0,0,1,0,'h3,1,   0,1,'h1,'h2,0, 0,0));
        tbl.push_back(mk(0,1,1,0,'h4,1,   1,1,'h3,'h4,0, 1,0));
        tbl.push_back(mk(0,0,0,0,0,1,     0,1,'h3,'h4,0, 0,0));
        for (int i = 0; i < tbl.size(); i++)
            step($sformatf("tbl%0d", i), tbl[i]);
`ifdef PRIM_STATS_EN
        total++;
        if (DropCount !== 16'd4) begin
            bad++;
            $display("FAIL drop_tbl: got %0d want 4", DropCount);
        end
`endif

        // TRI_FAN with rasterizer back-pressure after the first triangle.
        step("fan_p", mk(1,0,1,5,'h100,1, 0,1,'h3,'h4,0, 0,0));
        step("fan_a", mk(0,0,1,0,'h101,1, 0,1,'h3,'h4,0, 0,0));
        step("fan_b", mk(0,0,1,0,'h102,1, 1,2,'h100,'h101,'h102, 0,0));
        for (int i = 0; i < 3; i++)
            step($sformatf("fan_stall%0d", i), mk(0,0,1,0,'h103,0, 1,2,'h100,'h101,'h102, 0,0));
        step("fan_c", mk(0,0,1,0,'h103,1, 1,2,'h100,'h102,'h103, 0,0));
        step("fan_end", mk(0,1,0,0,0,1, 0,2,'h100,'h102,'h103, 1,0));

        // Reset asserted mid LINE_STRIP with a primitive pending.
        step("ls_a", mk(1,0,1,2,'h200,1, 0,2,'h100,'h102,'h103, 0,0));
        step("ls_b", mk(0,0,1,0,'h201,0, 1,1,'h200,'h201,0, 0,0));
        Draw = 0; Reset = 1'b0;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check("ls_reset", mk(0,0,0,0,0,0, 0,0,0,0,0, 0,0), 1'b0);
        Reset = 1'b1;
        step("ls2_a", mk(1,0,1,2,'h300,1, 0,0,0,0,0, 0,0));
        step("ls2_b", mk(0,0,1,0,'h301,1, 1,1,'h300,'h301,0, 0,0));
        step("ls2_c", mk(0,0,1,0,'h302,1, 1,1,'h301,'h302,0, 0,0));
        step("ls2_end", mk(0,1,0,0,0,1, 0,1,'h301,'h302,0, 1,0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
